// File: rtl/bch_syndrome_kes.sv
// BCH(15,7) t=2 decoder front-end over GF(2^4), p(x) = x^4 + x + 1.
// Serially accumulates syndromes S1 = r(a) and S3 = r(a^3) by Horner's rule,
// then solves the t=2 key equation directly (Peterson) for lambda1/lambda2.
module bch_syndrome_kes (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] lambda1,
  output logic [3:0] lambda2,
  output logic [3:0] syn1,
  output logic [3:0] syn3,
  output logic       no_error,
  output logic       uncorrectable
);

  localparam int unsigned GF_W  = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(14);
  localparam logic [GF_W-1:0]  ALPHA    = GF_W'(4'b0010);
  localparam logic [GF_W-1:0]  ALPHA3   = GF_W'(4'b1000);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC1 = 2'd1,
    CALC2 = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [GF_W-1:0]   cube;
  logic [GF_W-1:0]   inv;

  logic [GF_W-1:0]   s1_step;
  logic [GF_W-1:0]   s3_step;
  logic [GF_W-1:0]   cube_next;
  logic [GF_W-1:0]   inv_next;
  logic [GF_W-1:0]   lambda2_next;

  // Shift-and-add multiply, reducing by x^4 = x + 1 at every shift.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b);
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(GF_W); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? GF_W'(4'b0011) : GF_W'(4'b0000));
    end
    return acc;
  endfunction

  // Multiplicative inverse lookup; zero maps to zero so S1 = 0 zeroes lambda2.
  function automatic logic [GF_W-1:0] gf_inv(input logic [GF_W-1:0] a);
    logic [GF_W-1:0] r;
    case (a)
      4'h0: r = 4'h0;
      4'h1: r = 4'h1;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'hD;
      4'h5: r = 4'hB;
      4'h6: r = 4'h7;
      4'h7: r = 4'h6;
      4'h8: r = 4'hF;
      4'h9: r = 4'h2;
      4'hA: r = 4'hC;
      4'hB: r = 4'h5;
      4'hC: r = 4'hA;
      4'hD: r = 4'h4;
      4'hE: r = 4'h3;
      default: r = 4'h8;
    endcase
    return r;
  endfunction

  // Horner steps, cube/inverse and lambda2 datapath.
  always_comb begin
    s1_step      = gf_mul(syn1, ALPHA)  ^ {3'b000, in_bit};
    s3_step      = gf_mul(syn3, ALPHA3) ^ {3'b000, in_bit};
    cube_next    = gf_mul(gf_mul(syn1, syn1), syn1);
    inv_next     = gf_inv(syn1);
    lambda2_next = gf_mul(syn3 ^ cube, inv);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      count         <= '0;
      cube          <= '0;
      inv           <= '0;
      syn1          <= '0;
      syn3          <= '0;
      lambda1       <= '0;
      lambda2       <= '0;
      no_error      <= 1'b0;
      uncorrectable <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            syn1  <= s1_step;
            syn3  <= s3_step;
            count <= count + CNT_W'(1);
            if (count == LAST_BIT) begin
              state    <= CALC1;
              in_ready <= 1'b0;
            end
          end
        end
        CALC1: begin
          cube  <= cube_next;
          inv   <= inv_next;
          state <= CALC2;
        end
        CALC2: begin
          lambda1       <= syn1;
          lambda2       <= lambda2_next;
          no_error      <= (syn1 == '0) && (syn3 == '0);
          uncorrectable <= (syn1 == '0) && (syn3 != '0);
          out_valid     <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            syn1          <= '0;
            syn3          <= '0;
            count         <= '0;
            lambda1       <= '0;
            lambda2       <= '0;
            no_error      <= 1'b0;
            uncorrectable <= 1'b0;
            out_valid     <= 1'b0;
            in_ready      <= 1'b1;
            state         <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_kes.sv
// Directed bench for bch_syndrome_kes with hand-computed syndromes and locators.
module tb_bch_syndrome_kes;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] lambda1;
  logic [3:0] lambda2;
  logic [3:0] syn1;
  logic [3:0] syn3;
  logic       no_error;
  logic       uncorrectable;

  int n_cmp;
  int n_bad;

  bch_syndrome_kes dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_bit        (in_bit),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .lambda1       (lambda1),
    .lambda2       (lambda2),
    .syn1          (syn1),
    .syn3          (syn3),
    .no_error      (no_error),
    .uncorrectable (uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result bundle: {unc, no_err, syn3, syn1, lambda2, lambda1}.
  function automatic logic [31:0] pack(input logic u, input logic z, input logic [3:0] s3,
                                       input logic [3:0] s1, input logic [3:0] l2,
                                       input logic [3:0] l1);
    return {14'd0, u, z, s3, s1, l2, l1};
  endfunction

  function automatic logic [31:0] observed();
    return pack(uncorrectable, no_error, syn3, syn1, lambda2, lambda1);
  endfunction

  // Feed a codeword MSB (r14) first, then wait for out_valid; returns latency.
  task automatic send_frame(input logic [14:0] cw, input bit gaps, output int lat);
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_bit   = 1'b1;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_bit   = cw[i];
      @(negedge clk);
    end
    // Keep offering junk bits while calculating; they must be ignored.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_cleared"}, {out_valid, in_ready, observed()[17:0]}, {1'b0, 1'b1, 18'd0});
  endtask

  task automatic run_case(input string tag, input logic [14:0] cw, input logic [31:0] exp);
    int lat;
    send_frame(cw, 1'b0, lat);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_result"}, observed(), exp);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] exp_dbl;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, observed()[17:0]}, {1'b0, 1'b1, 18'd0});
    rst_n = 1'b1;
    @(negedge clk);

    exp_dbl = pack(1'b0, 1'b0, 4'h9, 4'h3, 4'h2, 4'h3);

    run_case("zero",   15'h0000, pack(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0));
    run_case("err_r0", 15'h0001, pack(1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h1));
    run_case("err_r14",15'h4000, pack(1'b0, 1'b0, 4'hF, 4'h9, 4'h0, 4'h9));
    run_case("err_r01",15'h0003, exp_dbl);
    run_case("err_3",  15'h0421, pack(1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0));

    // Input gaps plus 10 cycles of output backpressure.
    send_frame(15'h0003, 1'b1, lat);
    check("gap_valid", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("stall_hold", {14'd0, out_valid, in_ready, observed()[15:0]},
            {14'd0, 1'b1, 1'b0, exp_dbl[15:0]});
      check("stall_flags", observed(), exp_dbl);
      @(negedge clk);
    end
    handshake("gap");

    // Abort a frame part way through, then decode a clean one.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_reset_syn", {28'd0, syn1} | {28'd0, syn3}, 32'(syn1 | syn3) == 0 ? 32'hF : {28'd0, syn1 | syn3});
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset", {out_valid, in_ready, observed()[17:0]}, {1'b0, 1'b1, 18'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case("post_reset", 15'h0003, exp_dbl);

    // Reset while waiting in OUT.
    send_frame(15'h4000, 1'b0, lat);
    check("out_before_rst", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("out_reset", {out_valid, in_ready, observed()[17:0]}, {1'b0, 1'b1, 18'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case("final", 15'h0001, pack(1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
